// File: rtl/acc_pkg.sv
// Shared constants for the multi-channel accumulator: FSM state encoding and
// default widths.
package acc_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 16;
   localparam int DEF_NUM_CH = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: adder, wrap or clamp on carry-out, sticky overflow,
// clear-on-read. Define ACC_MULTI_SATURATE_EN to clamp instead of wrapping.
module acc_lane
   import acc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] add_data,
   input  logic              rd_clr,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   logic [ACC_W:0]   sum_s;
   logic [ACC_W-1:0] acc_d, acc_q;
   logic             ovf_d, ovf_q;

   // Next-state: clear, clear-on-read, or add with carry handling
   always_comb begin
      sum_s = {1'b0, acc_q} + (ACC_W+1)'(add_data);
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (rd_clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (add_en) begin
         if (sum_s[ACC_W]) begin
`ifdef ACC_MULTI_SATURATE_EN
            acc_d = {ACC_W{1'b1}};
`else
            acc_d = sum_s[ACC_W-1:0];
`endif
            ovf_d = 1'b1;
         end else begin
            acc_d = sum_s[ACC_W-1:0];
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/acc_multi.sv
// NUM_CH-channel accumulator with sticky overflow and a valid/ready drain
// stream. ACC_MULTI_SATURATE_EN selects clamping over wrap in every lane.
module acc_multi
   import acc_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  ACC_W  = DEF_ACC_W,
   parameter int  NUM_CH = DEF_NUM_CH,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic              dump,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [ACC_W-1:0]  out_data,
   output logic [NUM_CH-1:0] ovf,
   output logic              busy
);

   logic [0:0]      state_d, state_q;
   logic [CH_W-1:0] idx_d, idx_q;
   logic            draining_s;
   logic            accept_s;
   logic            handshake_s;
   logic            last_s;
   logic [ACC_W-1:0]  lane_acc_s [NUM_CH];
   logic [NUM_CH-1:0] lane_ovf_s;

   assign draining_s  = (state_q == ST_DRAIN);
   // rst_n gates in_ready so the source sees no acceptance while in reset
   assign in_ready    = rst_n && !clr && (state_q == ST_IDLE);
   assign accept_s    = in_valid && in_ready;
   assign handshake_s = draining_s && out_ready;
   assign last_s      = (idx_q == CH_W'(NUM_CH - 1));
   assign out_valid   = draining_s;
   assign busy        = draining_s;
   assign ovf         = lane_ovf_s;

   // Out-of-range channel indices match no lane, so such beats are dropped
   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      acc_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .add_en   (accept_s && (in_ch == CH_W'(g))),
         .add_data (in_data),
         .rd_clr   (handshake_s && (idx_q == CH_W'(g))),
         .acc      (lane_acc_s[g]),
         .ovf      (lane_ovf_s[g])
      );
   end

   // Output mux: current drain channel, forced to zero outside a drain
   always_comb begin
      out_ch   = '0;
      out_data = '0;
      if (draining_s) begin
         out_ch = idx_q;
         for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == CH_W'(i)) begin
               out_data = lane_acc_s[i];
            end else begin
               out_data = out_data;
            end
         end
      end else begin
         out_ch   = '0;
         out_data = '0;
      end
   end

   // FSM and drain index next-state
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (clr) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dump) begin
                  state_d = ST_DRAIN;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (handshake_s && last_s) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else if (handshake_s) begin
                  idx_d = idx_q + CH_W'(1);
               end else begin
                  idx_d = idx_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // FSM state and drain index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_acc_multi.sv
// Directed bench for acc_multi (DATA_W=8, ACC_W=10): a 4-channel DUT checked
// every cycle against an array model, plus a 5-channel DUT for index range.
module tb_acc_multi;

   localparam int MAXV = 1023;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_ch;
   logic [7:0] in_data;
   logic       dump;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_ch;
   logic [9:0] out_data;
   logic [3:0] ovf;
   logic       busy;

   logic       b_in_valid;
   logic       b_in_ready;
   logic [2:0] b_in_ch;
   logic [7:0] b_in_data;
   logic       b_dump;
   logic       b_out_valid;
   logic       b_out_ready;
   logic [2:0] b_out_ch;
   logic [9:0] b_out_data;
   logic [4:0] b_ovf;
   logic       b_busy;

   int cmp_cnt  = 0;
   int fail_cnt = 0;

   // Reference model state
   int         m_acc [4];
   logic [3:0] m_ovf;
   logic       m_drain;
   int         m_idx;

   acc_multi #(.DATA_W(8), .ACC_W(10), .NUM_CH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
      .dump(dump), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_data(out_data), .ovf(ovf), .busy(busy)
   );

   acc_multi #(.DATA_W(8), .ACC_W(10), .NUM_CH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ch(b_in_ch), .in_data(b_in_data),
      .dump(b_dump), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_ch(b_out_ch), .out_data(b_out_data), .ovf(b_ovf), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt = cmp_cnt + 1;
      if (act !== exp) begin
         fail_cnt = fail_cnt + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_sum(input int a, input int b);
      if (a + b > MAXV) begin
`ifdef ACC_MULTI_SATURATE_EN
         return MAXV;
`else
         return a + b - (MAXV + 1);
`endif
      end
      return a + b;
   endfunction

   // Behavioural model: totals per channel, drain as a walk over channels
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < 4; i++) m_acc[i] <= 0;
         m_ovf   <= 4'b0000;
         m_drain <= 1'b0;
         m_idx   <= 0;
      end else if (!m_drain) begin
         if (in_valid) begin
            m_acc[in_ch] <= m_sum(m_acc[in_ch], int'(in_data));
            if (m_acc[in_ch] + int'(in_data) > MAXV) m_ovf[in_ch] <= 1'b1;
         end
         if (dump) begin
            m_drain <= 1'b1;
            m_idx   <= 0;
         end
      end else if (out_ready) begin
         m_acc[m_idx] <= 0;
         m_ovf[m_idx] <= 1'b0;
         m_idx        <= (m_idx == 3) ? 0 : m_idx + 1;
         if (m_idx == 3) m_drain <= 1'b0;
      end
   end

   // Per-cycle comparison of the 4-channel DUT against the model
   always @(negedge clk) begin
      chk("in_ready",  32'(in_ready),  32'(rst_n && !clr && !m_drain));
      chk("out_valid", 32'(out_valid), 32'(m_drain));
      chk("busy",      32'(busy),      32'(m_drain));
      chk("out_ch",    32'(out_ch),    m_drain ? 32'(m_idx) : 32'd0);
      chk("out_data",  32'(out_data),  m_drain ? 32'(m_acc[m_idx]) : 32'd0);
      chk("ovf",       32'(ovf),       32'(m_ovf));
   end

   task automatic drive(input logic iv, input int ch, input int d,
                        input logic dmp, input logic ordy, input logic c);
      in_valid  = iv;
      in_ch     = 2'(ch);
      in_data   = 8'(d);
      dump      = dmp;
      out_ready = ordy;
      clr       = c;
      @(posedge clk);
      #1;
   endtask

   // Expects the DUT to have just entered DRAIN; walks all four handshakes
   task automatic drain_expect(input int e0, input int e1, input int e2, input int e3);
      int e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_ch",    32'(out_ch),    32'(k));
         chk("drain_data",  32'(out_data),  32'(e[k]));
         drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      end
      chk("drain_done_busy", 32'(busy), 32'd0);
   endtask

   int exp2;

   initial begin
      rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = 2'd0; in_data = 8'd0;
      dump = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_ch = 3'd0; b_in_data = 8'd0; b_dump = 1'b0; b_out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: ch1 accumulation then full drain
      drive(1'b1, 1, 8'hAA, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1, 8'hAF, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1, 8'hEA, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 32'h243, 0, 0);
      chk("t1_ovf", 32'(ovf), 32'd0);

      // 2: ch2 overflow
      for (int k = 0; k < 5; k++) drive(1'b1, 2, 8'hFF, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("t2_ovf_set", 32'(ovf), 32'b0100);
`ifdef ACC_MULTI_SATURATE_EN
      exp2 = 32'h3FF;
`else
      exp2 = 32'h0FB;
`endif
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 0, exp2, 0);
      chk("t2_ovf_clr", 32'(ovf), 32'd0);

      // 3: stall on ch1
      drive(1'b1, 1, 8'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1, 8'h22, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 0, 8'h01, 1'b0, 1'b0, 1'b0);
         chk("t3_stall_ch",   32'(out_ch),   32'd1);
         chk("t3_stall_data", 32'(out_data), 32'h032);
         chk("t3_in_ready",   32'(in_ready), 32'd0);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      chk("t3_idle", 32'(busy), 32'd0);
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 0, 0, 0);

      // 4: clr aborts a drain
      drive(1'b1, 0, 8'h33, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2, 8'h44, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      chk("t4_ch0_data", 32'(out_data), 32'h033);
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      chk("t4_out_valid", 32'(out_valid), 32'd0);
      chk("t4_busy",      32'(busy),      32'd0);
      clr = 1'b0;
      #1;
      chk("t4_in_ready",  32'(in_ready),  32'd1);
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 0, 0, 0);

      // 5: dump with a same-cycle beat
      drive(1'b1, 3, 8'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 3, 8'h05, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 0, 0, 32'h015);

      // 6a: asynchronous reset mid-drain
      for (int k = 0; k < 5; k++) drive(1'b1, 2, 8'hFF, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1, 8'h07, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
      chk("t6_pre_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_busy",      32'(busy),      32'd0);
      chk("t6_in_ready",  32'(in_ready),  32'd0);
      chk("t6_ovf",       32'(ovf),       32'd0);
      chk("t6_out_data",  32'(out_data),  32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain_expect(0, 0, 0, 0);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

      // 6b: 5-channel instance, out-of-range index discarded
      b_in_valid = 1'b1; b_in_ch = 3'd1; b_in_data = 8'h20;
      @(posedge clk); #1;
      b_in_ch = 3'd7; b_in_data = 8'h55;
      #1;
      chk("b_in_ready_ch7", 32'(b_in_ready), 32'd1);
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_dump = 1'b1; b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_dump = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("b_drain_ch",   32'(b_out_ch),   32'(k));
         chk("b_drain_data", 32'(b_out_data), (k == 1) ? 32'h020 : 32'd0);
         @(posedge clk); #1;
      end
      chk("b_busy", 32'(b_busy), 32'd0);
      chk("b_ovf",  32'(b_ovf),  32'd0);
      b_out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("b_rst_in_ready", 32'(b_in_ready), 32'd0);
      chk("b_rst_valid",    32'(b_out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/acc_multi.md
Name: acc_multi

Overview:
Multi-channel, parametrised successor to the single 8-bit accumulator.
- Accumulates unsigned samples into NUM_CH independent ACC_W-bit accumulators, selected per beat by a channel index.
- Flags overflow per channel with a sticky bit.
- On request, drains every channel total through a valid/ready output stream, clearing each channel as it is read.
- Sits between a sample source and a statistics/readout consumer.

Parameters:
DATA_W, 8, input sample width (unsigned)
ACC_W, 16, accumulator width; must be >= DATA_W
NUM_CH, 4, number of channels; must be >= 2
CH_W, $clog2(NUM_CH), channel index width (localparam, derived)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all channels and flags
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_ch  in  CH_W  target channel of the input sample
in_data  in  DATA_W  input sample, unsigned
dump  in  1  single-cycle request to drain all channels
out_valid  out  1  output total valid
out_ready  in  1  consumer accepts the output total
out_ch  out  CH_W  channel index of out_data
out_data  out  ACC_W  channel total
ovf  out  NUM_CH  sticky per-channel overflow flags
busy  out  1  high while a drain is in progress

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - all accumulators 0; ovf 0; state IDLE; drain index 0.
  - out_valid 0, out_ch 0, out_data 0, busy 0, in_ready 0 while rst_n is low.
- FSM states: IDLE and DRAIN.
- IDLE:
  - in_ready = !clr.
  - A beat is accepted when in_valid && in_ready. On that edge: acc[in_ch] <= acc[in_ch] + zero-extended in_data. The new value is visible one cycle after acceptance.
  - Wrap (default build): the sum is taken mod 2^ACC_W; a carry out of ACC_W sets ovf[in_ch].
  - in_ch >= NUM_CH: the beat is accepted and discarded; no state change.
  - dump high in IDLE: next state DRAIN, drain index 0. A beat accepted in the same cycle is applied and is included in the drained totals.
- DRAIN:
  - in_ready 0, busy 1, out_valid 1.
  - out_ch = drain index; out_data = acc[drain index]. Both are combinational from state and are 0 when out_valid is 0.
  - out_valid && !out_ready: out_ch and out_data hold stable.
  - Handshake (out_ready high): acc[index] <= 0, ovf[index] <= 0, index increments. The handshake on index NUM_CH-1 returns the FSM to IDLE with index 0.
  - dump in DRAIN is ignored.
- clr:
  - Highest priority below reset. On the edge, all accumulators and ovf go to 0, state goes to IDLE, index goes to 0.
  - While clr is high, in_ready is 0 and no beat is accepted.
  - clr in DRAIN aborts the drain; out_valid is 0 from the next cycle.
- A single channel cannot overflow by more than one wrap per beat, because ACC_W >= DATA_W.

Optional Feature:
Macro: ACC_MULTI_SATURATE_EN
- Defined: an overflowing sum clamps to 2^ACC_W-1 and sets ovf[ch]. Further beats keep the channel at max.
- Undefined: modular wrap as described in Behaviour, with ovf set.
- All other behaviour is identical in both builds.

Decomposition:
- Package acc_pkg holds:
  - state encoding for IDLE/DRAIN (2-value enum or localparams);
  - default DATA_W, ACC_W, NUM_CH constants.
- One sub-module, acc_lane, is natural. It covers a single channel register, adder, wrap/saturate logic, sticky ovf bit, and clear-on-read. acc_multi instantiates NUM_CH lanes plus the FSM, drain index and output mux.

Test Plan (DATA_W=8, ACC_W=10, NUM_CH=4 unless noted):
1. Reset, then ch1 beats 0xAA, 0xAF, 0xEA, then dump with out_ready=1 -> outputs (ch,data) = (0,0x000), (1,0x243), (2,0x000), (3,0x000); ovf=0; busy low after 4th handshake.
2. ch2 five beats of 0xFF -> wrap build: acc2=0x0FB, ovf[2]=1. SATURATE build: acc2=0x3FF, ovf[2]=1. After dump, ovf[2]=0.
3. Drain with out_ready low 3 cycles on ch1 -> out_ch=1 and out_data unchanged across stall; in_ready=0 throughout; all totals 0 after drain.
4. clr asserted one cycle after ch0 handshake in DRAIN -> next cycle out_valid=0, busy=0, in_ready=1; next drain returns all zeros.
5. dump and in_valid (ch3, 0x05) in the same IDLE cycle -> beat accepted; ch3 drained total = prior value + 5.
6. rst_n pulled low between clock edges mid-accumulation -> acc, ovf, out_valid, busy, in_ready read 0 before the next edge; same for in_ch=7 with NUM_CH=5, where the beat is accepted and no channel changes.
